// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg -- shared constants for the exception controller.
//   ExcCode values, mem_exc bit indices, exception vector addresses,
//   FSM state encoding and the bad-address source select.
package exc_ctrl_pkg;

  // ExcCode values reported to cp0
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // mem_exc bit positions
  localparam int B_FETCH_ADEL = 0;
  localparam int B_RI         = 1;
  localparam int B_OV         = 2;
  localparam int B_SYS        = 3;
  localparam int B_BP         = 4;
  localparam int B_DATA_ADEL  = 5;
  localparam int B_DATA_ADES  = 6;
  localparam int B_ERET       = 7;

  // exception vectors (Status.BEV selects boot vs. normal)
  localparam logic [31:0] VEC_BEV  = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM = 32'h8000_0180;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  // where BadVAddr comes from
  typedef enum logic [1:0] {
    BV_ZERO  = 2'd0,
    BV_PC    = 2'd1,
    BV_DADDR = 2'd2
  } bv_sel_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if -- MEM-stage, cp0 and fetch-redirect signals of exc_ctrl.
//   slave  : exc_ctrl side (consumes MEM/cp0 state, produces cp0 update,
//            pipeline control and the fetch redirect)
//   master : pipeline / cp0 / fetch side
interface exc_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [7:0]  mem_exc;
  logic [31:0] mem_daddr;
  logic        int_response;
  logic        status_bev;
  logic [31:0] epc_in;
  logic        redirect_ready;

  logic        mem_cancel;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  mem_valid, mem_pc, mem_bd, mem_exc, mem_daddr, int_response,
           status_bev, epc_in, redirect_ready,
    output mem_cancel, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, stall, redirect_valid, redirect_pc
  );

  modport master (
    output mem_valid, mem_pc, mem_bd, mem_exc, mem_daddr, int_response,
           status_bev, epc_in, redirect_ready,
    input  mem_cancel, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl_prio.sv
// exc_prio -- combinational exception priority encoder.
//   in : int_req (pending interrupt), mem_exc[7:0] (MEM-stage flags)
//   out: excode (winning ExcCode), bv_sel (BadVAddr source),
//        is_eret (ERET with nothing of higher priority -> commits)
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic [7:0] mem_exc,
  output logic [4:0] excode,
  output bv_sel_e    bv_sel,
  output logic       is_eret
);

  always_comb begin
    excode  = EXC_INT;
    bv_sel  = BV_ZERO;
    is_eret = 1'b0;
    if (int_req)                   excode = EXC_INT;
    else if (mem_exc[B_FETCH_ADEL]) begin
      excode = EXC_ADEL;
      bv_sel = BV_PC;
    end
    else if (mem_exc[B_RI])        excode = EXC_RI;
    else if (mem_exc[B_OV])        excode = EXC_OV;
    else if (mem_exc[B_SYS])       excode = EXC_SYS;
    else if (mem_exc[B_BP])        excode = EXC_BP;
    else if (mem_exc[B_DATA_ADEL]) begin
      excode = EXC_ADEL;
      bv_sel = BV_DADDR;
    end
    else if (mem_exc[B_DATA_ADES]) begin
      excode = EXC_ADES;
      bv_sel = BV_DADDR;
    end
    else if (mem_exc[B_ERET])      is_eret = 1'b1;
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl -- precise exception / ERET controller at the MEM (commit) stage.
//   clk, reset (async, active high)
//   timer_int  : extra interrupt source, present only with EXC_TIMER_INT_EN
//   bus        : exc_ctrl_if.slave (MEM stage, cp0, fetch redirect)
// Sequence: trigger in IDLE -> FLUSH (exc_valid/flush one cycle) ->
// REDIRECT (hold redirect_valid/redirect_pc until redirect_ready) -> IDLE.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
`ifdef EXC_TIMER_INT_EN
  input  logic      timer_int,
`endif
  exc_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        int_req, trigger;
  logic [4:0]  excode;
  bv_sel_e     bv_sel;
  logic        is_eret;
  logic [31:0] badvaddr;

  logic [4:0]  excode_q;
  logic        bd_q, eret_q;
  logic [31:0] epc_q, badvaddr_q, rpc_q;
  logic        exc_valid_c, flush_c, stall_c, rv_c;

`ifdef EXC_TIMER_INT_EN
  assign int_req = bus.int_response | timer_int;
`else
  assign int_req = bus.int_response;
`endif

  exc_prio u_prio (
    .int_req (int_req),
    .mem_exc (bus.mem_exc),
    .excode  (excode),
    .bv_sel  (bv_sel),
    .is_eret (is_eret)
  );

  // Only IDLE accepts a trigger; while flushing, MEM holds a dying instruction.
  assign trigger        = (state_q == S_IDLE) && bus.mem_valid &&
                          ((|bus.mem_exc) || int_req);
  // ERET commits normally; everything else is killed in MEM.
  assign bus.mem_cancel = trigger && !is_eret;

  always_comb begin
    case (bv_sel)
      BV_PC:    badvaddr = bus.mem_pc;
      BV_DADDR: badvaddr = bus.mem_daddr;
      default:  badvaddr = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      excode_q   <= 5'd0;
      bd_q       <= 1'b0;
      eret_q     <= 1'b0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      rpc_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (trigger) begin
        excode_q   <= is_eret ? EXC_INT : excode;
        bd_q       <= bus.mem_bd;
        eret_q     <= is_eret;
        epc_q      <= bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
        badvaddr_q <= badvaddr;
        // captured here so the redirect target stays stable even if cp0 moves
        rpc_q      <= is_eret ? bus.epc_in :
                      (bus.status_bev ? VEC_BEV : VEC_NORM);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    exc_valid_c = 1'b0;
    flush_c     = 1'b0;
    stall_c     = 1'b1;
    rv_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = 1'b0;
        if (trigger) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        exc_valid_c = 1'b1;
        flush_c     = 1'b1;
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        rv_c = 1'b1;
        if (bus.redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All of these derive from registers only (state_q or capture regs).
  assign bus.exc_valid      = exc_valid_c;
  assign bus.flush          = flush_c;
  assign bus.stall          = stall_c;
  assign bus.redirect_valid = rv_c;
  assign bus.redirect_pc    = rpc_q;
  assign bus.exc_excode     = excode_q;
  assign bus.exc_bd         = bd_q;
  assign bus.exc_eret       = eret_q;
  assign bus.exc_epc        = epc_q;
  assign bus.exc_badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl -- directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic clk;
  logic reset;
`ifdef EXC_TIMER_INT_EN
  logic timer_int;
`endif
  int n_cmp = 0;
  int n_err = 0;

  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef EXC_TIMER_INT_EN
    .timer_int (timer_int),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.mem_valid      = 1'b0;
    bus.mem_pc         = 32'd0;
    bus.mem_bd         = 1'b0;
    bus.mem_exc        = 8'd0;
    bus.mem_daddr      = 32'd0;
    bus.int_response   = 1'b0;
`ifdef EXC_TIMER_INT_EN
    timer_int          = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    bus.status_bev     = 1'b0;
    bus.epc_in         = 32'd0;
    bus.redirect_ready = 1'b0;
    #12;
    chk("rst_stall", bus.stall, 0);
    chk("rst_rv", bus.redirect_valid, 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    chk("rst_excv", bus.exc_valid, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_code", bus.exc_excode, 0);
    reset = 1'b0;
    tick();

    // Ov, no delay slot, BEV=0; a second trigger during FLUSH is ignored
    bus.mem_valid = 1; bus.mem_exc = 8'h04; bus.mem_pc = 32'h8000_1000;
    bus.redirect_ready = 1;
    #1;
    chk("ov_cancel", bus.mem_cancel, 1);
    chk("ov_stall_n", bus.stall, 0);
    tick();
    chk("ov_excv", bus.exc_valid, 1);
    chk("ov_flush", bus.flush, 1);
    chk("ov_code", bus.exc_excode, 12);
    chk("ov_epc", bus.exc_epc, 32'h8000_1000);
    chk("ov_bd", bus.exc_bd, 0);
    chk("ov_bva", bus.exc_badvaddr, 0);
    chk("ov_rv_n", bus.redirect_valid, 0);
    bus.mem_exc = 8'h08; bus.mem_pc = 32'h8000_1004;
    #1;
    chk("flush_ign_cancel", bus.mem_cancel, 0);
    tick();
    clr_in();
    chk("ov_rv", bus.redirect_valid, 1);
    chk("ov_rpc", bus.redirect_pc, 32'h8000_0180);
    chk("ov_excv_n", bus.exc_valid, 0);
    chk("ov_flush_n", bus.flush, 0);
    tick();
    chk("ov_done_rv", bus.redirect_valid, 0);
    chk("ov_done_stall", bus.stall, 0);
    chk("flush_ign_code", bus.exc_excode, 12);

    // data AdES in a delay slot
    bus.mem_valid = 1; bus.mem_exc = 8'h40; bus.mem_pc = 32'h8000_2004;
    bus.mem_bd = 1; bus.mem_daddr = 32'h0000_1235;
    #1;
    chk("ades_cancel", bus.mem_cancel, 1);
    tick();
    clr_in();
    chk("ades_code", bus.exc_excode, 5);
    chk("ades_epc", bus.exc_epc, 32'h8000_2000);
    chk("ades_bd", bus.exc_bd, 1);
    chk("ades_bva", bus.exc_badvaddr, 32'h0000_1235);
    tick();
    tick();

    // interrupt beats RI, BEV=1
    bus.mem_valid = 1; bus.mem_exc = 8'h02; bus.int_response = 1;
    bus.status_bev = 1; bus.mem_pc = 32'h8000_0010;
    #1;
    chk("int_cancel", bus.mem_cancel, 1);
    tick();
    clr_in();
    bus.status_bev = 0;
    chk("int_code", bus.exc_excode, 0);
    chk("int_bva", bus.exc_badvaddr, 0);
    tick();
    chk("int_rpc", bus.redirect_pc, 32'hBFC0_0380);
    tick();

    // ERET with redirect_ready low for three REDIRECT cycles
    bus.redirect_ready = 0;
    bus.mem_valid = 1; bus.mem_exc = 8'h80; bus.epc_in = 32'h8000_3000;
    bus.mem_pc = 32'h8000_0020;
    #1;
    chk("eret_cancel", bus.mem_cancel, 0);
    tick();
    clr_in();
    bus.epc_in = 32'h1111_1110;
    chk("eret_excv", bus.exc_valid, 1);
    chk("eret_flag", bus.exc_eret, 1);
    chk("eret_code", bus.exc_excode, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("eret_rv", bus.redirect_valid, 1);
      chk("eret_rpc", bus.redirect_pc, 32'h8000_3000);
      if (k == 3) bus.redirect_ready = 1;
    end
    tick();
    chk("eret_rv_end", bus.redirect_valid, 0);

    // fetch AdEL outranks data AdEL and ERET; badvaddr = PC
    bus.mem_valid = 1; bus.mem_exc = 8'hA1; bus.mem_pc = 32'h8000_4001;
    bus.mem_daddr = 32'h0000_5555;
    #1;
    chk("fadel_cancel", bus.mem_cancel, 1);
    tick();
    clr_in();
    chk("fadel_code", bus.exc_excode, 4);
    chk("fadel_bva", bus.exc_badvaddr, 32'h8000_4001);
    chk("fadel_eret", bus.exc_eret, 0);
    tick();
    tick();

    // interrupt without a valid MEM instruction waits
    bus.int_response = 1;
    #1;
    chk("int_nv_cancel", bus.mem_cancel, 0);
    tick();
    chk("int_nv_excv", bus.exc_valid, 0);
    chk("int_nv_stall", bus.stall, 0);
    bus.mem_valid = 1; bus.mem_pc = 32'h8000_0040;
    #1;
    chk("int_v_cancel", bus.mem_cancel, 1);
    bus.redirect_ready = 0;
    tick();
    clr_in();
    chk("int_v_excv", bus.exc_valid, 1);
    tick();
    chk("rst_mid_rv_pre", bus.redirect_valid, 1);
    // reset in the middle of REDIRECT
    #2;
    reset = 1;
    #1;
    chk("rst_mid_rv", bus.redirect_valid, 0);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_flush", bus.flush, 0);
    chk("rst_mid_rpc", bus.redirect_pc, 0);
    #3;
    reset = 0;
    bus.redirect_ready = 1;
    tick();
    chk("post_rst_stall", bus.stall, 0);

    // timer interrupt source
`ifdef EXC_TIMER_INT_EN
    timer_int = 1;
`endif
    bus.mem_valid = 1; bus.mem_pc = 32'h8000_0050;
    #1;
`ifdef EXC_TIMER_INT_EN
    chk("timer_cancel", bus.mem_cancel, 1);
    tick();
    clr_in();
    chk("timer_excv", bus.exc_valid, 1);
    chk("timer_code", bus.exc_excode, 0);
`else
    chk("timer_cancel", bus.mem_cancel, 0);
    tick();
    clr_in();
    chk("timer_excv", bus.exc_valid, 0);
    chk("timer_stall", bus.stall, 0);
`endif
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
